// File: rtl/tl_pkg.sv
// tl_pkg: TileLink-UL opcodes, default field widths and the response queue entry.
package tl_pkg;
   localparam logic [2:0] PUT_FULL        = 3'd0;
   localparam logic [2:0] PUT_PARTIAL     = 3'd1;
   localparam logic [2:0] GET             = 3'd4;
   localparam logic [2:0] ACCESS_ACK      = 3'd0;
   localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;
   localparam int TL_SIZE_WD   = 3;
   localparam int TL_SOURCE_WD = 32;
   localparam int TL_DATA_WD   = 256;
   localparam int TL_TMR_WD    = 8;
   typedef struct packed {
      logic [2:0]              opcode;
      logic [TL_SIZE_WD-1:0]   size;
      logic [TL_SOURCE_WD-1:0] source;
      logic                    denied;
      logic [TL_DATA_WD-1:0]   data;
      logic [TL_TMR_WD-1:0]    timer;
   } resp_entry_t;
endpackage

// File: rtl/tl_resp_queue.sv
// tl_resp_queue: FIFO of pending D responses, each with a countdown timer.
//   push/push_entry enqueue at the tail, pop dequeues the head,
//   head/head_ready expose the oldest entry once its timer hits 0, full blocks push.
module tl_resp_queue
   import tl_pkg::*;
#(
   parameter int QDEPTH = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        push,
   input  resp_entry_t push_entry,
   input  logic        pop,
   output resp_entry_t head,
   output logic        head_ready,
   output logic        full
);
   localparam int PW = $clog2(QDEPTH);
   resp_entry_t q [QDEPTH];
   logic [PW-1:0] wp, rp;
   logic empty;
   assign empty = (wp == rp) && !full;
   assign head = q[rp];
   assign head_ready = !empty && head.timer == '0;
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         wp   <= '0;
         rp   <= '0;
         full <= 1'b0;
         for (int i = 0; i < QDEPTH; i++) q[i] <= '0;
      end else begin
         for (int i = 0; i < QDEPTH; i++)
            if (q[i].timer != '0) q[i].timer <= q[i].timer - 1'b1;
         if (push) begin
            q[wp] <= push_entry;
            wp    <= wp + 1'b1;
         end
         if (pop) rp <= rp + 1'b1;
         // Pointers alone cannot tell full from empty, so the flag tracks it.
         if (push != pop) full <= push && (wp + 1'b1 == rp);
      end
endmodule

// File: rtl/tl_ul_responder.sv
// tl_ul_responder: TileLink-UL slave with a byte-masked local memory.
//   A channel (a_*): Get/PutFull/PutPartial requests, a_ready low when the queue is full.
//   D channel (d_*): AccessAck/AccessAckData in acceptance order, LATENCY after accept.
module tl_ul_responder
   import tl_pkg::*;
#(
   parameter int               SIZE_WD   = TL_SIZE_WD,
   parameter int               ADDR_WD   = 36,
   parameter int               DATA_WD   = TL_DATA_WD,
   parameter int               SOURCE_WD = TL_SOURCE_WD,
   parameter int               SINK_WD   = 32,
   parameter logic [ADDR_WD-1:0] BASE_ADDR = '0,
   parameter int               MEM_DEPTH = 64,
   parameter int               LATENCY   = 2,
   parameter int               QDEPTH    = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 a_valid,
   output logic                 a_ready,
   input  logic [2:0]           a_opcode,
   input  logic [SIZE_WD-1:0]   a_size,
   input  logic [SOURCE_WD-1:0] a_source,
   input  logic [ADDR_WD-1:0]   a_address,
   input  logic [DATA_WD/8-1:0] a_mask,
   input  logic [DATA_WD-1:0]   a_data,
   input  logic                 a_corrupt,
   output logic                 d_valid,
   input  logic                 d_ready,
   output logic [2:0]           d_opcode,
   output logic [1:0]           d_param,
   output logic [SIZE_WD-1:0]   d_size,
   output logic [SOURCE_WD-1:0] d_source,
   output logic [SINK_WD-1:0]   d_sink,
   output logic                 d_denied,
   output logic [DATA_WD-1:0]   d_data,
   output logic                 d_corrupt
);
   localparam int MASK_WD = DATA_WD / 8;
   localparam int OFF_WD  = $clog2(MASK_WD);
   localparam int IDX_WD  = $clog2(MEM_DEPTH);
   logic [DATA_WD-1:0] mem [MEM_DEPTH];
   logic [ADDR_WD-1:0] off;
   logic [IDX_WD-1:0]  idx;
   logic borrow, is_put, is_get, denied, accept, full, head_ready;
   resp_entry_t ent, head;
   logic [TL_TMR_WD-1:0] unused_timer;
   assign accept = a_valid && a_ready;
   assign is_put = a_opcode == PUT_FULL || a_opcode == PUT_PARTIAL;
   assign is_get = a_opcode == GET;
   // borrow flags an address below BASE_ADDR
   assign {borrow, off} = {1'b0, a_address} - {1'b0, BASE_ADDR};
   assign idx = off[OFF_WD +: IDX_WD];
   assign denied = !(is_put || is_get) || a_size > SIZE_WD'(OFF_WD) || borrow ||
                   off >= ADDR_WD'(MEM_DEPTH * MASK_WD) || (is_put && a_corrupt);
   always_comb begin
      ent        = '0;
      ent.opcode = is_get ? ACCESS_ACK_DATA : ACCESS_ACK;
      ent.size   = a_size;
      ent.source = a_source;
      ent.denied = denied;
      ent.data   = is_get && !denied ? mem[idx] : '0;
      ent.timer  = TL_TMR_WD'(LATENCY - 1);
   end
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
      end else if (accept && is_put && !denied) begin
         for (int b = 0; b < MASK_WD; b++)
            if (a_mask[b]) mem[idx][8*b +: 8] <= a_data[8*b +: 8];
      end
   tl_resp_queue #(.QDEPTH(QDEPTH)) u_queue (
      .clock      (clock),
      .reset      (reset),
      .push       (accept),
      .push_entry (ent),
      .pop        (d_valid && d_ready),
      .head       (head),
      .head_ready (head_ready),
      .full       (full)
   );
   assign unused_timer = head.timer;
   assign a_ready   = !full;
   assign d_valid   = head_ready;
   assign d_opcode  = d_valid ? head.opcode : '0;
   assign d_size    = d_valid ? head.size : '0;
   assign d_source  = d_valid ? head.source : '0;
   assign d_denied  = d_valid && head.denied;
   assign d_data    = d_valid ? head.data : '0;
   assign d_corrupt = d_valid && head.denied && head.opcode == ACCESS_ACK_DATA;
   assign d_param   = '0;
   assign d_sink    = '0;
endmodule

// File: tb/tb_tl_ul_responder.sv
// tb_tl_ul_responder: table-driven plus scoreboard checks of the TL-UL responder.
module tb_tl_ul_responder;
   localparam int LAT = 2;
   logic clock = 1'b0;
   logic reset = 1'b0;
   logic a_valid = 1'b0, a_ready, a_corrupt = 1'b0;
   logic [2:0] a_opcode = '0, a_size = '0;
   logic [31:0] a_source = '0, a_mask = '0;
   logic [35:0] a_address = '0;
   logic [255:0] a_data = '0;
   logic d_valid, d_ready = 1'b1, d_denied, d_corrupt;
   logic [2:0] d_opcode, d_size;
   logic [1:0] d_param;
   logic [31:0] d_source, d_sink;
   logic [255:0] d_data;

   tl_ul_responder dut (
      .clock(clock), .reset(reset),
      .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_size(a_size),
      .a_source(a_source), .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
      .a_corrupt(a_corrupt),
      .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
      .d_size(d_size), .d_source(d_source), .d_sink(d_sink), .d_denied(d_denied),
      .d_data(d_data), .d_corrupt(d_corrupt)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [2:0] op; logic [2:0] size; logic [35:0] addr; logic [31:0] mask;
      logic [255:0] data; logic corrupt; logic exp_den; logic [2:0] exp_op;
   } vec_t;
   typedef struct {
      logic [2:0] op; logic [2:0] size; logic [31:0] src; logic den;
      logic [255:0] data; logic cor; int acc;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   logic [255:0] model [64];
   vec_t tbl [13];
   int checks = 0, failures = 0, cyc = 0, nresp = 0, last_acc = 0;
   logic exact_lat = 1'b1, stalled = 1'b0;
   logic [297:0] snap = '0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [2:0] op, input logic [2:0] size, input logic [35:0] addr,
                               input logic [31:0] mask, input logic [255:0] data, input logic corrupt,
                               input logic den, input logic [2:0] eop);
      vec_t v;
      v.op = op; v.size = size; v.addr = addr; v.mask = mask; v.data = data;
      v.corrupt = corrupt; v.exp_den = den; v.exp_op = eop;
      return v;
   endfunction

   // Called at posedge+1; returns at posedge+1 after the accept edge.
   task automatic send(input vec_t v, input logic [31:0] src);
      int n = 0;
      exp_t x;
      a_valid = 1'b1; a_opcode = v.op; a_size = v.size; a_source = src;
      a_address = v.addr; a_mask = v.mask; a_data = v.data; a_corrupt = v.corrupt;
      @(negedge clock);
      while (!a_ready && n < 200) begin @(negedge clock); n++; end
      if (!a_ready) chk("a_accept_timeout", 0, 1);
      else begin
         x.op = v.exp_op; x.size = v.size; x.src = src; x.den = v.exp_den;
         x.data = (v.exp_op == 3'd1 && !v.exp_den) ? model[v.addr[10:5]] : '0;
         x.cor = v.exp_den && v.exp_op == 3'd1;
         x.acc = cyc + 1;
         last_acc = x.acc;
         sb.push_back(x);
         if (!v.exp_den && (v.op == 3'd0 || v.op == 3'd1))
            for (int b = 0; b < 32; b++)
               if (v.mask[b]) model[v.addr[10:5]][8*b +: 8] = v.data[8*b +: 8];
      end
      @(posedge clock); #1;
      a_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin @(negedge clock); n++; end
      chk("drain_left", sb.size(), 0);
      @(posedge clock); #1;
   endtask

   always @(negedge clock) begin
      if (reset && d_valid && d_ready) begin
         if (sb.size() == 0) chk("spurious_response", 1, 0);
         else begin
            e = sb.pop_front();
            chk("d_opcode", d_opcode, e.op);
            chk("d_size", d_size, e.size);
            chk("d_source", d_source, e.src);
            chk("d_denied", d_denied, e.den);
            chk("d_data", d_data, e.data);
            chk("d_corrupt", d_corrupt, e.cor);
            chk("d_param_sink", {d_param, d_sink}, 0);
            if (exact_lat) chk("latency", cyc + 1 - e.acc, LAT);
            else chk("latency_min", (cyc + 1 - e.acc) >= LAT, 1);
            nresp++;
         end
      end
      if (reset && stalled)
         chk("d_stable", {d_valid, d_opcode, d_size, d_source, d_denied, d_data, d_corrupt}, snap);
      stalled <= reset && d_valid && !d_ready;
      snap <= {d_valid, d_opcode, d_size, d_source, d_denied, d_data, d_corrupt};
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0, a0;
      for (int i = 0; i < 64; i++) model[i] = '0;
      tbl[0]  = mk(3'd0, 3'd5, 36'd0,    32'hFFFFFFFF, {32{8'hA5}}, 1'b0, 1'b0, 3'd0);
      tbl[1]  = mk(3'd4, 3'd5, 36'd0,    32'hFFFFFFFF, '0,          1'b0, 1'b0, 3'd1);
      tbl[2]  = mk(3'd1, 3'd0, 36'd32,   32'h00000001, {32{8'hFF}}, 1'b0, 1'b0, 3'd0);
      tbl[3]  = mk(3'd4, 3'd5, 36'd32,   32'hFFFFFFFF, '0,          1'b0, 1'b0, 3'd1);
      tbl[4]  = mk(3'd4, 3'd5, 36'd2048, 32'hFFFFFFFF, '0,          1'b0, 1'b1, 3'd1);
      tbl[5]  = mk(3'd2, 3'd5, 36'd0,    32'hFFFFFFFF, {32{8'h11}}, 1'b0, 1'b1, 3'd0);
      tbl[6]  = mk(3'd4, 3'd6, 36'd0,    32'hFFFFFFFF, '0,          1'b0, 1'b1, 3'd1);
      tbl[7]  = mk(3'd0, 3'd5, 36'd0,    32'hFFFFFFFF, {32{8'h3C}}, 1'b1, 1'b1, 3'd0);
      tbl[8]  = mk(3'd4, 3'd5, 36'd0,    32'hFFFFFFFF, '0,          1'b0, 1'b0, 3'd1);
      tbl[9]  = mk(3'd1, 3'd5, 36'd101,  32'h000000F0, {8{32'h01234567}}, 1'b0, 1'b0, 3'd0);
      tbl[10] = mk(3'd4, 3'd5, 36'd96,   32'hFFFFFFFF, '0,          1'b0, 1'b0, 3'd1);
      tbl[11] = mk(3'd4, 3'd5, 36'd2047, 32'hFFFFFFFF, '0,          1'b0, 1'b0, 3'd1);
      tbl[12] = mk(3'd7, 3'd0, 36'd0,    32'hFFFFFFFF, '0,          1'b0, 1'b1, 3'd0);
      repeat (3) @(posedge clock);
      #1 reset = 1'b1;
      @(negedge clock);
      chk("rst_d_valid", d_valid, 0);
      chk("rst_a_ready", a_ready, 1);
      chk("rst_d_data", d_data, 0);
      chk("rst_d_fields", {d_opcode, d_denied, d_corrupt, d_source}, 0);
      @(posedge clock); #1;
      for (int i = 0; i < 13; i++) send(tbl[i], 32'(i + 1));
      drain();
      // Full queue with D stalled: 4 accepted, 5th must wait.
      exact_lat = 1'b0;
      d_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(mk(3'd4, 3'd5, 36'(32 * i), '1, '0, 1'b0, 1'b0, 3'd1), 32'(100 + i));
      @(negedge clock);
      chk("a_ready_full", a_ready, 0);
      a_valid = 1'b1; a_opcode = 3'd4; a_address = 36'd128; a_source = 32'd104;
      repeat (3) begin @(negedge clock); chk("a_stall", a_ready, 0); end
      @(posedge clock); #1;
      d_ready = 1'b1;
      send(mk(3'd4, 3'd5, 36'd128, '1, '0, 1'b0, 1'b0, 3'd1), 32'd104);
      drain();
      exact_lat = 1'b1;
      // Reset with 3 entries in flight.
      d_ready = 1'b0;
      for (int i = 0; i < 3; i++) send(mk(3'd4, 3'd5, 36'd0, '1, '0, 1'b0, 1'b0, 3'd1), 32'(300 + i));
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      #1 chk("reset_d_valid", d_valid, 0);
      sb.delete();
      for (int i = 0; i < 64; i++) model[i] = '0;
      @(posedge clock); #1;
      reset = 1'b1;
      d_ready = 1'b1;
      repeat (5) begin @(negedge clock); chk("post_reset_idle", d_valid, 0); end
      @(posedge clock); #1;
      send(mk(3'd4, 3'd5, 36'd0, '1, '0, 1'b0, 1'b0, 3'd1), 32'd400);
      drain();
      // Back-to-back stream.
      n0 = nresp;
      a0 = 0;
      for (int i = 0; i < 16; i++) begin
         send(mk(3'd4, 3'd5, 36'(32 * i), '1, '0, 1'b0, 1'b0, 3'd1), 32'(200 + i));
         if (i == 0) a0 = last_acc;
      end
      drain();
      chk("stream_count", nresp - n0, 16);
      chk("stream_span", last_acc - a0, 15);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
